// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: operations, register-file write port and
// write-back stage state.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [4:0] {
        OP_NOP,
        OP_ADD,
        OP_ADDI,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_LUI,
        OP_JAL,
        OP_JALR,
        OP_BEQ,
        OP_BNE,
        OP_LB,
        OP_LH,
        OP_LW,
        OP_LBU,
        OP_LHU,
        OP_SB,
        OP_SH,
        OP_SW
    } operation_e;

    typedef struct packed {
        logic            valid;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } rd_port_t;

    typedef enum logic [0:0] {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_e;

    function automatic logic is_load(input operation_e op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Load data alignment: selects the addressed byte/half from a raw memory word,
// sign/zero extends it, and flags misaligned halfword/word accesses.
module wb_load_align
    import riscv_pkg::*;
(
    input  operation_e      op_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        data_o       = rdata_i;
        misaligned_o = 1'b0;
        case (op_i)
            OP_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: data_o = {24'd0, byte_sel};
            OP_LH: begin
                data_o       = {{16{half_sel[15]}}, half_sel};
                misaligned_o = off_i[0];
            end
            OP_LHU: begin
                data_o       = {16'd0, half_sel};
                misaligned_o = off_i[0];
            end
            OP_LW:   misaligned_o = (off_i != 2'd0);
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires instructions, completes loads from data memory
// and drives the register-file write port and retired-instruction counter.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter int unsigned INSTRET_W    = 64
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [XLEN-1:0]      pc_i,
    input  operation_e           operation_i,
    input  logic [4:0]           rd_addr_i,
    input  logic                 rd_wrt_ena_i,
    input  logic [XLEN-1:0]      result_i,
    input  logic                 dmem_rvalid_i,
    input  logic [XLEN-1:0]      dmem_rdata_i,
    output rd_port_t             rd_port_o,
    output logic                 load_err_o,
    output logic [INSTRET_W-1:0] instret_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

    wb_state_e            state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    rd_port_t             rd_port_q, rd_port_d;
    logic                 load_err_q, load_err_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    operation_e           ld_op_q, ld_op_d;
    logic [4:0]           ld_rd_q, ld_rd_d;
    logic [1:0]           ld_off_q, ld_off_d;

    operation_e           align_op;
    logic [1:0]           align_off;
    logic [XLEN-1:0]      align_data;
    logic                 align_misaligned;
    logic                 accept;

    // The PC travels with the instruction for debug visibility only.
    logic unused_pc;
    assign unused_pc = ^pc_i;

    assign ready_o = (state_q == WB_IDLE);
    assign accept  = valid_i && ready_o;

    // In IDLE the aligner checks the incoming load; while waiting it formats the response.
    assign align_op  = (state_q == WB_IDLE) ? operation_i : ld_op_q;
    assign align_off = (state_q == WB_IDLE) ? result_i[1:0] : ld_off_q;

    wb_load_align u_align (
        .op_i         (align_op),
        .off_i        (align_off),
        .rdata_i      (dmem_rdata_i),
        .data_o       (align_data),
        .misaligned_o (align_misaligned)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rd_port_d       = rd_port_q;
        rd_port_d.valid = 1'b0;
        load_err_d      = 1'b0;
        instret_d       = instret_q;
        ld_op_d         = ld_op_q;
        ld_rd_d         = ld_rd_q;
        ld_off_d        = ld_off_q;

        case (state_q)
            WB_IDLE: begin
                if (accept) begin
                    if (is_load(operation_i)) begin
                        ld_op_d  = operation_i;
                        ld_rd_d  = rd_addr_i;
                        ld_off_d = result_i[1:0];
                        if (align_misaligned) begin
                            load_err_d = 1'b1;
                            instret_d  = instret_q + INSTRET_W'(1);
                        end else begin
                            state_d = WB_LOAD_WAIT;
                            cnt_d   = 8'd0;
                        end
                    end else begin
                        instret_d = instret_q + INSTRET_W'(1);
                        if (rd_wrt_ena_i && (rd_addr_i != 5'd0)) begin
                            rd_port_d = '{valid: 1'b1, addr: rd_addr_i, data: result_i};
                        end
                    end
                end
            end
            WB_LOAD_WAIT: begin
                // A response arriving on the final allowed cycle still completes the load.
                if (dmem_rvalid_i) begin
                    state_d   = WB_IDLE;
                    instret_d = instret_q + INSTRET_W'(1);
                    if (ld_rd_q != 5'd0) begin
                        rd_port_d = '{valid: 1'b1, addr: ld_rd_q, data: align_data};
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d    = WB_IDLE;
                    load_err_d = 1'b1;
                    instret_d  = instret_q + INSTRET_W'(1);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= WB_IDLE;
            cnt_q      <= 8'd0;
            rd_port_q  <= '0;
            load_err_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_port_q  <= rd_port_d;
            load_err_q <= load_err_d;
            instret_q  <= instret_d;
        end
    end

    // Load capture registers are only meaningful in LOAD_WAIT, so they carry no reset.
    always_ff @(posedge clk_i) begin
        ld_op_q  <= ld_op_d;
        ld_rd_q  <= ld_rd_d;
        ld_off_q <= ld_off_d;
    end

    assign rd_port_o  = rd_port_q;
    assign load_err_o = load_err_q;
    assign instret_o  = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected
// write-backs/errors, a negedge monitor pops and compares them.
module tb_writeback_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] pc_i = 32'h0;
    operation_e  operation_i = OP_NOP;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        rd_wrt_ena_i = 1'b0;
    logic [31:0] result_i = 32'h0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = 32'h0;
    rd_port_t    rd_port_o;
    logic        load_err_o;
    logic [63:0] instret_o;

    writeback_stage #(.LOAD_TIMEOUT(16), .INSTRET_W(64)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .pc_i          (pc_i),
        .operation_i   (operation_i),
        .rd_addr_i     (rd_addr_i),
        .rd_wrt_ena_i  (rd_wrt_ena_i),
        .result_i      (result_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .rd_port_o     (rd_port_o),
        .load_err_o    (load_err_o),
        .instret_o     (instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [63:0] ins;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_ins = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        exp_ins++;
        e.err = 1'b0; e.addr = a; e.data = d; e.ins = exp_ins;
        sb.push_back(e);
    endfunction

    function automatic void expect_err();
        exp_t e;
        exp_ins++;
        e.err = 1'b1; e.addr = 5'd0; e.data = 32'd0; e.ins = exp_ins;
        sb.push_back(e);
    endfunction

    // Monitor: every presented write or error must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn_i && (rd_port_o.valid || load_err_o)) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: valid=%0b err=%0b addr=%0d data=0x%0h, none expected",
                         rd_port_o.valid, load_err_o, rd_port_o.addr, rd_port_o.data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_is_err", {63'd0, load_err_o}, {63'd0, e.err});
                check("out_is_write", {63'd0, rd_port_o.valid}, {63'd0, !e.err});
                if (!e.err) begin
                    check("wr_addr", {59'd0, rd_port_o.addr}, {59'd0, e.addr});
                    check("wr_data", {32'd0, rd_port_o.data}, {32'd0, e.data});
                end
                check("instret_at_retire", instret_o, e.ins);
            end
        end
    end

    task automatic issue(input operation_e op, input logic [4:0] rd, input logic wen,
                         input logic [31:0] res);
        int n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) check("ready_wait_timeout", 64'd0, 64'd1);
        operation_i  = op;
        rd_addr_i    = rd;
        rd_wrt_ena_i = wen;
        result_i     = res;
        pc_i         = pc_i + 32'd4;
        valid_i      = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic load_resp(input int gap, input logic [31:0] rdata);
        repeat (gap) begin
            @(posedge clk); #1;
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_port", {21'd0, rd_port_o}, 64'd0);
        check("reset_load_err", {63'd0, load_err_o}, 64'd0);
        check("reset_instret", instret_o, 64'd0);
        check("reset_ready", {63'd0, ready_o}, 64'd1);
        rstn_i = 1'b1;
        @(posedge clk); #1;

        expect_wr(5'd5, 32'h0000_1234);
        issue(OP_ADDI, 5'd5, 1'b1, 32'h0000_1234);

        expect_wr(5'd3, 32'hFFFF_FF80);
        issue(OP_LB, 5'd3, 1'b1, 32'h0000_0103);
        load_resp(0, 32'h80AA_BBCC);
        expect_wr(5'd3, 32'h0000_0080);
        issue(OP_LBU, 5'd3, 1'b1, 32'h0000_0103);
        load_resp(0, 32'h80AA_BBCC);

        expect_wr(5'd4, 32'hFFFF_8001);
        issue(OP_LH, 5'd4, 1'b1, 32'h0000_0102);
        check("ready_low_in_wait", {63'd0, ready_o}, 64'd0);
        load_resp(2, 32'h8001_0000);
        expect_wr(5'd4, 32'h0000_8001);
        issue(OP_LHU, 5'd4, 1'b1, 32'h0000_0102);
        load_resp(2, 32'h8001_0000);

        exp_ins++;
        issue(OP_ADD, 5'd0, 1'b1, 32'h0000_0055);
        check("rd0_no_write", {63'd0, rd_port_o.valid}, 64'd0);
        check("rd0_instret", instret_o, exp_ins);

        expect_wr(5'd6, 32'h0000_007F);
        issue(OP_LB, 5'd6, 1'b1, 32'h0000_0100);
        load_resp(1, 32'h1234_567F);
        expect_wr(5'd8, 32'hFFFF_F00D);
        issue(OP_LH, 5'd8, 1'b1, 32'h0000_0100);
        load_resp(0, 32'h1234_F00D);
        expect_wr(5'd9, 32'h0000_00BE);
        issue(OP_LBU, 5'd9, 1'b1, 32'h0000_0101);
        load_resp(0, 32'hDEAD_BEEF);
        expect_wr(5'd10, 32'hDEAD_BEEF);
        issue(OP_LW, 5'd10, 1'b1, 32'h0000_0100);
        load_resp(0, 32'hDEAD_BEEF);

        exp_ins++;
        issue(OP_SW, 5'd0, 1'b0, 32'h0000_0200);
        check("store_instret", instret_o, exp_ins);

        expect_wr(5'd1, 32'h0000_0011);
        expect_wr(5'd2, 32'h0000_0022);
        issue(OP_ADDI, 5'd1, 1'b1, 32'h0000_0011);
        issue(OP_ADDI, 5'd2, 1'b1, 32'h0000_0022);

        expect_err();
        issue(OP_LW, 5'd11, 1'b1, 32'h0000_0100);
        repeat (15) @(posedge clk);
        #1;
        check("timeout_not_early_err", {63'd0, load_err_o}, 64'd0);
        check("timeout_not_early_ready", {63'd0, ready_o}, 64'd0);
        @(posedge clk); #1;
        check("timeout_err", {63'd0, load_err_o}, 64'd1);
        check("timeout_ready", {63'd0, ready_o}, 64'd1);

        expect_err();
        issue(OP_LW, 5'd11, 1'b1, 32'h0000_0102);
        check("lw_misaligned_err", {63'd0, load_err_o}, 64'd1);
        check("lw_misaligned_ready", {63'd0, ready_o}, 64'd1);
        expect_err();
        issue(OP_LHU, 5'd12, 1'b1, 32'h0000_0101);
        check("lhu_misaligned_ready", {63'd0, ready_o}, 64'd1);

        expect_wr(5'd13, 32'hCAFE_F00D);
        issue(OP_LW, 5'd13, 1'b1, 32'h0000_0104);
        load_resp(15, 32'hCAFE_F00D);

        exp_ins++;
        issue(OP_LB, 5'd0, 1'b1, 32'h0000_0100);
        load_resp(0, 32'h0000_00FF);
        check("load_rd0_no_write", {63'd0, rd_port_o.valid}, 64'd0);
        check("load_rd0_instret", instret_o, exp_ins);
        check("load_rd0_ready", {63'd0, ready_o}, 64'd1);

        issue(OP_LW, 5'd14, 1'b1, 32'h0000_0100);
        repeat (2) @(posedge clk);
        #1;
        rstn_i = 1'b0;
        #1;
        check("midload_reset_rd_port", {21'd0, rd_port_o}, 64'd0);
        check("midload_reset_instret", instret_o, 64'd0);
        check("midload_reset_ready", {63'd0, ready_o}, 64'd1);
        exp_ins = 64'd0;
        @(posedge clk); @(posedge clk); #1;
        rstn_i = 1'b1;
        load_resp(0, 32'h1111_1111);
        check("stale_rvalid_instret", instret_o, 64'd0);

        expect_wr(5'd7, 32'h0000_ABCD);
        issue(OP_SUB, 5'd7, 1'b1, 32'h0000_ABCD);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
